// File: rtl/silicon_tinytapeout_lm07.sv
// LM07/LM70 SPI temperature reader driving a 7-segment display (TinyTapeout tile).
// Define SEG_ACTIVE_LOW_EN for a common-anode display (segments and digit enables inverted).
module silicon_tinytapeout_lm07 #(
  parameter int unsigned SCK_HALF    = 2,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned MUX_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic SEG_POL = 1'b1;
`else
  localparam logic SEG_POL = 1'b0;
`endif

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
  localparam logic [7:0] MUX_LAST  = 8'(MUX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bits_q, bits_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  temp_q, temp_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;

  logic [7:0]  mux_q, mux_d;
  logic        phase_q, phase_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  en_q, en_d;

  logic [11:0] c_s, f_s, sel_s, val_s, tens_w, units_w;
  logic [3:0]  tens_s, units_s, digit_s;
  logic        sio_s;
  logic        unused_bits;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign sio_s = uio_in[2];

  // SPI read sequencer: IDLE gap, 8 SCK rises with MSB-first capture, one DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    temp_d  = temp_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    case (state_q)
      ST_IDLE: begin
        sck_d = 1'b0;
        if (cnt_q == IDLE_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = 8'd0;
          bits_d  = 4'd0;
          sh_d    = 8'd0;
          cs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          cs_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 8'd0;
          if (!sck_q) begin
            sck_d  = 1'b1;
            sh_d   = {sh_q[6:0], sio_s};
            bits_d = bits_q + 4'd1;
          end else if (bits_q == 4'd8) begin
            // last bit: CS rises together with SCK so no extra fall is seen while selected
            state_d = ST_DONE;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
          end else begin
            sck_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        temp_d  = sh_q;
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      bits_q  <= 4'd0;
      sh_q    <= 8'd0;
      temp_q  <= 8'd0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      temp_q  <= temp_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
    end
  end

  // Reading to clamped two-digit decimal; negative readings display as zero in either unit
  always_comb begin
    c_s   = {4'd0, temp_q[6:0], 1'b0};
    f_s   = (c_s * 12'd9) / 12'd5 + 12'd32;
    sel_s = ui_in[2] ? f_s : c_s;
    if (temp_q[7]) begin
      val_s = 12'd0;
    end else if (sel_s > 12'd99) begin
      val_s = 12'd99;
    end else begin
      val_s = sel_s;
    end
    tens_w  = val_s / 12'd10;
    units_w = val_s % 12'd10;
    tens_s  = tens_w[3:0];
    units_s = units_w[3:0];
  end

  // Digit selection: fixed onboard digit, or tens/units multiplexing starting with tens
  always_comb begin
    mux_d   = 8'd0;
    phase_d = 1'b0;
    digit_s = tens_s;
    en_d    = 2'b00;
    if (ui_in[0]) begin
      if (mux_q == MUX_LAST) begin
        mux_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        mux_d   = mux_q + 8'd1;
        phase_d = phase_q;
      end
      digit_s = phase_q ? units_s : tens_s;
      en_d    = phase_q ? 2'b10 : 2'b01;
    end else begin
      digit_s = ui_in[1] ? units_s : tens_s;
    end
    seg_d = seg7(digit_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_q   <= 8'd0;
      phase_q <= 1'b0;
      seg_q   <= 7'h3F;
      en_q    <= 2'b00;
    end else begin
      mux_q   <= mux_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  // dp follows the unit switch directly so it is also valid while reset is held
  assign uo_out      = {ui_in[2] ^ SEG_POL, seg_q ^ {7{SEG_POL}}};
  assign uio_out     = {3'b000, en_q ^ {2{SEG_POL}}, 1'b0, sck_q, cs_q};
  assign uio_oe      = 8'b0001_1011;
  assign unused_bits = &{1'b0, ena, ui_in[7:3], uio_in[7:3], uio_in[1:0],
                         tens_w[11:4], units_w[11:4]};

endmodule

// File: tb/tb_silicon_tinytapeout_lm07.sv
// Self-checking bench for silicon_tinytapeout_lm07: sensor model, vector table, random readings.
module tb_silicon_tinytapeout_lm07;
  localparam int SCK_HALF    = 2;
  localparam int IDLE_CYCLES = 8;
  localparam int MUX_CYCLES  = 16;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  silicon_tinytapeout_lm07 #(
    .SCK_HALF(SCK_HALF), .IDLE_CYCLES(IDLE_CYCLES), .MUX_CYCLES(MUX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sensor_word = 16'h0000;
  int   idx = 15, rises = 0, rises_last = 0, reads_done = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0;

  // Sensor: MSB presented while deselected, next bit after every SCK fall
  always @(negedge clk) begin
    if (uio_out[0]) begin
      if (!prev_cs) begin
        rises_last = rises;
        reads_done = reads_done + 1;
      end
      rises = 0;
      idx   = 15;
    end else begin
      if (uio_out[1] && !prev_sck) rises = rises + 1;
      if (!uio_out[1] && prev_sck && idx > 0) idx = idx - 1;
    end
    uio_in   = {5'b00000, sensor_word[idx], 2'b00};
    prev_cs  = uio_out[0];
    prev_sck = uio_out[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_reads(input int n);
    int start;
    bit done;
    start = reads_done;
    done  = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (reads_done >= start + n) done = 1'b1;
    end
    if (!done) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL read_timeout: got %0d reads expected %0d", reads_done - start, n);
    end
  endtask

  function automatic int model_value(input logic [7:0] b, input logic fahr);
    int c, v;
    if (b[7]) return 0;
    c = 2 * int'(b);
    v = fahr ? (c * 9) / 5 + 32 : c;
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [7:0] model_uo(input logic [7:0] b, input logic [7:0] ui);
    int v, d;
    v = model_value(b, ui[2]);
    d = ui[1] ? (v % 10) : (v / 10);
    return {ui[2], SEG_TAB[d]};
  endfunction

  typedef struct {
    logic [15:0] word;
    logic [7:0]  ui;
    logic [7:0]  exp_uo;
  } vec_t;

  vec_t vecs [18];

  initial begin
    int   len;
    bit   found;
    logic [1:0] pen, cur;
    logic [7:0] b, ui;

    vecs[0]  = '{16'h041F, 8'h00, 8'h3F};
    vecs[1]  = '{16'h041F, 8'h02, 8'h7F};
    vecs[2]  = '{16'h0B9F, 8'h00, 8'h5B};
    vecs[3]  = '{16'h0B9F, 8'h02, 8'h5B};
    vecs[4]  = '{16'h259F, 8'h00, 8'h07};
    vecs[5]  = '{16'h259F, 8'h02, 8'h66};
    vecs[6]  = '{16'h311F, 8'h00, 8'h6F};
    vecs[7]  = '{16'h311F, 8'h02, 8'h7F};
    vecs[8]  = '{16'h041F, 8'h04, 8'hE6};
    vecs[9]  = '{16'h041F, 8'h06, 8'hFD};
    vecs[10] = '{16'h191F, 8'h04, 8'hEF};
    vecs[11] = '{16'h191F, 8'h06, 8'hEF};
    vecs[12] = '{16'hF01F, 8'h00, 8'h3F};
    vecs[13] = '{16'hF01F, 8'h02, 8'h3F};
    vecs[14] = '{16'h011F, 8'h00, 8'h3F};
    vecs[15] = '{16'h011F, 8'h02, 8'h5B};
    vecs[16] = '{16'h039F, 8'h02, 8'h7D};
    vecs[17] = '{16'h101F, 8'h00, 8'h4F};

    // Reset state
    ui_in = 8'h04;
    repeat (3) @(negedge clk);
    check("reset_uo_dp", {24'd0, uo_out}, 32'h0000_00BF);
    ui_in = 8'h00;
    #1;
    check("reset_uo", {24'd0, uo_out}, 32'h0000_003F);
    check("reset_uio_out", {24'd0, uio_out}, 32'h0000_0001);
    check("uio_oe", {24'd0, uio_oe}, 32'h0000_001B);
    @(negedge clk);
    rst = 1'b0;

    // First IDLE after reset lasts IDLE_CYCLES clocks
    len = 0;
    for (int i = 1; i <= 100 && len == 0; i++) begin
      @(negedge clk);
      if (!uio_out[0]) len = i;
    end
    check("first_idle_len", len, IDLE_CYCLES);

    // Directed onboard vectors
    for (int i = 0; i < 18; i++) begin
      sensor_word = vecs[i].word;
      ui_in       = vecs[i].ui;
      wait_reads(2);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_uo", i), {24'd0, uo_out}, {24'd0, vecs[i].exp_uo});
      check($sformatf("vec%0d_en", i), {30'd0, uio_out[4:3]}, 32'd0);
      check($sformatf("vec%0d_rises", i), rises_last, 8);
    end

    // External multiplexed display, 32 C
    sensor_word = 16'h101F;
    ui_in       = 8'h01;
    wait_reads(2);
    repeat (3) @(negedge clk);
    pen   = uio_out[4:3];
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      cur = uio_out[4:3];
      if (pen == 2'b10 && cur == 2'b01) found = 1'b1;
      pen = cur;
    end
    check("ext_align", {31'd0, found}, 32'd1);
    for (int k = 0; k < 2 * MUX_CYCLES; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("ext_en_%0d", k), {30'd0, uio_out[4:3]},
            (k < MUX_CYCLES) ? 32'd1 : 32'd2);
      check($sformatf("ext_uo_%0d", k), {24'd0, uo_out},
            (k < MUX_CYCLES) ? 32'h0000_004F : 32'h0000_005B);
    end

    // Random readings against the reference model
    for (int r = 0; r < 20; r++) begin
      b  = 8'($urandom_range(0, 255));
      ui = {5'b00000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0};
      sensor_word = {b, 8'h1F};
      ui_in       = ui;
      wait_reads(2);
      repeat (3) @(negedge clk);
      check($sformatf("rand%0d_b%02h_ui%02h", r, b, ui), {24'd0, uo_out},
            {24'd0, model_uo(b, ui)});
    end

    // Reset in the middle of a transfer
    sensor_word = 16'h259F;
    ui_in       = 8'h00;
    wait_reads(2);
    repeat (3) @(negedge clk);
    check("pre_abort_uo", {24'd0, uo_out}, 32'h0000_0007);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!uio_out[0] && rises >= 3) found = 1'b1;
    end
    check("abort_reach_shift", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_cs_sck", {30'd0, uio_out[1:0]}, 32'd1);
    check("abort_uo", {24'd0, uo_out}, 32'h0000_003F);
    repeat (2) @(negedge clk);
    sensor_word = 16'h311F;
    rst = 1'b0;
    wait_reads(1);
    check("post_abort_rises", rises_last, 8);
    repeat (3) @(negedge clk);
    check("post_abort_uo", {24'd0, uo_out}, 32'h0000_006F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
